// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference: loader trigger, layer-1 then layer-2 MAC passes with running weight addresses.
// Latency: N_HID*(N_IN+ROM_LAT+1) + N_OUT*(N_HID+ROM_LAT+1) + 3 cycles after load_ready; no backpressure, start ignored while busy.
// SNN_CTRL_WDOG_EN adds a LOAD_TIMEOUT watchdog on the loader wait (err pulse, back to IDLE).
module snn_inference_ctrl #(
   parameter int N_IN         = 784,
   parameter int N_HID        = 32,
   parameter int N_OUT        = 10,
   parameter int ROM_LAT      = 1,
   parameter int LOAD_TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        load_trigger,
   input  logic        load_ready,
   output logic [9:0]  in_addr,
   output logic [14:0] w1_addr,
   output logic [4:0]  hid_addr,
   output logic [8:0]  w2_addr,
   output logic        mac_sel,
   output logic        mac_en,
   output logic        mac_clr,
   output logic        hid_we,
   output logic [4:0]  hid_waddr,
   output logic        out_we,
   output logic [3:0]  out_waddr,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [3:0] {
      IDLE, LOAD, L1_CLR, L1_ISSUE, L1_DRAIN, L1_WR,
      L2_CLR, L2_ISSUE, L2_DRAIN, L2_WR, DONE
   } state_t;

   localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [9:0]    I_LAST = 10'(N_IN - 1);
   localparam logic [4:0]    N_LAST = 5'(N_HID - 1);
   localparam logic [4:0]    J_LAST = 5'(N_HID - 1);
   localparam logic [3:0]    K_LAST = 4'(N_OUT - 1);
   localparam logic [DW-1:0] D_LAST = DW'(ROM_LAT - 1);

   state_t              state_q, state_d;
   logic [9:0]          i_q, i_d;
   logic [4:0]          n_q, n_d;
   logic [14:0]         w1_q, w1_d;
   logic [4:0]          j_q, j_d;
   logic [3:0]          k_q, k_d;
   logic [8:0]          w2_q, w2_d;
   logic [DW-1:0]       d_q, d_d;
   logic [ROM_LAT-1:0]  sr_q, sr_d;
   logic                sel_q, sel_d;
   logic                issue;

`ifdef SNN_CTRL_WDOG_EN
   localparam int WW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_LAST = WW'(LOAD_TIMEOUT - 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          wd_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         n_q     <= '0;
         w1_q    <= '0;
         j_q     <= '0;
         k_q     <= '0;
         w2_q    <= '0;
         d_q     <= '0;
         sr_q    <= '0;
         sel_q   <= 1'b0;
`ifdef SNN_CTRL_WDOG_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         n_q     <= n_d;
         w1_q    <= w1_d;
         j_q     <= j_d;
         k_q     <= k_d;
         w2_q    <= w2_d;
         d_q     <= d_d;
         sr_q    <= sr_d;
         sel_q   <= sel_d;
`ifdef SNN_CTRL_WDOG_EN
         wd_q    <= wd_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      n_d          = n_q;
      w1_d         = w1_q;
      j_d          = j_q;
      k_d          = k_q;
      w2_d         = w2_q;
      d_d          = d_q;
      sel_d        = sel_q;
      issue        = 1'b0;
      load_trigger = 1'b0;
      mac_clr      = 1'b0;
      hid_we       = 1'b0;
      out_we       = 1'b0;
      done         = 1'b0;
`ifdef SNN_CTRL_WDOG_EN
      wd_d         = '0;
      wd_err       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               load_trigger = 1'b1;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            if (load_ready) begin
               state_d = L1_CLR;
`ifdef SNN_CTRL_WDOG_EN
            end else if (wd_q == WD_LAST) begin
               wd_err  = 1'b1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
`endif
            end
         end
         L1_CLR: begin
            mac_clr = 1'b1;
            sel_d   = 1'b0;
            i_d     = '0;
            n_d     = '0;
            w1_d    = '0;
            state_d = L1_ISSUE;
         end
         L1_ISSUE: begin
            issue = 1'b1;
            if (i_q == I_LAST) begin
               d_d     = '0;
               state_d = L1_DRAIN;
            end else begin
               i_d  = i_q + 10'd1;
               w1_d = w1_q + 15'd1;
            end
         end
         L1_DRAIN: begin
            if (d_q == D_LAST) state_d = L1_WR;
            else               d_d     = d_q + 1'b1;
         end
         L1_WR: begin
            hid_we  = 1'b1;
            mac_clr = 1'b1;
            if (n_q == N_LAST) begin
               state_d = L2_CLR;
            end else begin
               n_d     = n_q + 5'd1;
               i_d     = '0;
               w1_d    = w1_q + 15'd1;
               state_d = L1_ISSUE;
            end
         end
         L2_CLR: begin
            mac_clr = 1'b1;
            sel_d   = 1'b1;
            j_d     = '0;
            k_d     = '0;
            w2_d    = '0;
            state_d = L2_ISSUE;
         end
         L2_ISSUE: begin
            issue = 1'b1;
            if (j_q == J_LAST) begin
               d_d     = '0;
               state_d = L2_DRAIN;
            end else begin
               j_d  = j_q + 5'd1;
               w2_d = w2_q + 9'd1;
            end
         end
         L2_DRAIN: begin
            if (d_q == D_LAST) state_d = L2_WR;
            else               d_d     = d_q + 1'b1;
         end
         L2_WR: begin
            out_we  = 1'b1;
            mac_clr = 1'b1;
            if (k_q == K_LAST) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + 4'd1;
               j_d     = '0;
               w2_d    = w2_q + 9'd1;
               state_d = L2_ISSUE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // mac_en trails the issue flag by the ROM read latency
   always_comb begin
      sr_d    = '0;
      sr_d[0] = issue;
      for (int b = 1; b < ROM_LAT; b++) sr_d[b] = sr_q[b-1];
   end

   assign in_addr   = i_q;
   assign w1_addr   = w1_q;
   assign hid_addr  = j_q;
   assign w2_addr   = w2_q;
   assign hid_waddr = n_q;
   assign out_waddr = k_q;
   assign mac_sel   = sel_q;
   assign mac_en    = sr_q[ROM_LAT-1];
   assign busy      = (state_q != IDLE);

`ifdef SNN_CTRL_WDOG_EN
   assign err = wd_err;
`else
   logic unused_cfg;
   assign unused_cfg = ^LOAD_TIMEOUT;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Scoreboarded bench for snn_inference_ctrl: directed runs, start pulses while busy, mid-run reset, loader stall.
module tb_snn_inference_ctrl;
   localparam int N_IN  = 784;
   localparam int N_HID = 32;
   localparam int N_OUT = 10;
   localparam int LOAD_TIMEOUT = 2048;

   localparam int EV_LT   = 0;
   localparam int EV_HID  = 1;
   localparam int EV_OUT  = 2;
   localparam int EV_DONE = 3;
   localparam int EV_ERR  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        load_ready = 1'b0;
   logic        load_trigger;
   logic [9:0]  in_addr;
   logic [14:0] w1_addr;
   logic [4:0]  hid_addr;
   logic [8:0]  w2_addr;
   logic        mac_sel, mac_en, mac_clr, hid_we, out_we, busy, done, err;
   logic [4:0]  hid_waddr;
   logic [3:0]  out_waddr;

   snn_inference_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_trigger(load_trigger),
      .load_ready(load_ready), .in_addr(in_addr), .w1_addr(w1_addr),
      .hid_addr(hid_addr), .w2_addr(w2_addr), .mac_sel(mac_sel), .mac_en(mac_en),
      .mac_clr(mac_clr), .hid_we(hid_we), .hid_waddr(hid_waddr), .out_we(out_we),
      .out_waddr(out_waddr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int kind;
      int idx;
      int waddr;
      int mac_cnt;
      int gap;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  last_cyc = 0;
   int  mac_cnt = 0;
   bit  busy_chk = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int idx, input int waddr, input int mc, input int gap);
      ev_t e;
      e.kind = kind; e.idx = idx; e.waddr = waddr; e.mac_cnt = mc; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // One full inference: trigger, 32 hidden writes, 10 output writes, done
   task automatic push_run();
      push(EV_LT, 0, 0, 0, -1);
      for (int n = 0; n < N_HID; n++)
         push(EV_HID, n, n*N_IN + N_IN - 1, (n+1)*N_IN, (n == 0) ? -1 : N_IN + 2);
      for (int k = 0; k < N_OUT; k++)
         push(EV_OUT, k, k*N_HID + N_HID - 1, N_HID*N_IN + (k+1)*N_HID,
              (k == 0) ? N_HID + 3 : N_HID + 2);
      push(EV_DONE, 0, 0, N_HID*N_IN + N_OUT*N_HID, 1);
   endtask

   task automatic handle(input int kind, input int idx, input int addr);
      ev_t e;
      if (kind == EV_LT) mac_cnt = 0;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_event: got kind %0d idx %0d, expected no event", kind, idx);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         if (kind == EV_HID || kind == EV_OUT) begin
            check("write_index", idx, e.idx);
            check("weight_addr_at_write", addr, e.waddr);
         end
         if (kind != EV_LT) check("mac_en_count", mac_cnt, e.mac_cnt);
         if (e.gap >= 0) check("event_spacing", cyc - last_cyc, e.gap);
         if (kind == EV_DONE) begin
            check("busy_in_done", busy, 1);
            busy_chk = 1'b1;
         end
      end
      last_cyc = cyc;
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on every DUT event
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (busy_chk) begin
            check("busy_after_done", busy, 0);
            busy_chk = 1'b0;
         end
         if (mac_en) mac_cnt++;
         if (load_trigger) handle(EV_LT, 0, 0);
         if (hid_we)       handle(EV_HID, int'(hid_waddr), int'(w1_addr));
         if (out_we)       handle(EV_OUT, int'(out_waddr), int'(w2_addr));
         if (done)         handle(EV_DONE, 0, 0);
         if (err)          handle(EV_ERR, 0, 0);
      end else begin
         busy_chk = 1'b0;
      end
   end

   function automatic longint all_outputs();
      return longint'({load_trigger, in_addr, w1_addr, hid_addr, w2_addr, mac_sel, mac_en,
                       mac_clr, hid_we, hid_waddr, out_we, out_waddr, busy, done, err});
   endfunction

   task automatic wait_write(input bit l2, input int idx, input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 30000 && !seen; c++) begin
         @(negedge clk);
         if (l2) seen = out_we && (out_waddr == idx[3:0]);
         else    seen = hid_we && (hid_waddr == idx[4:0]);
      end
      check(name, seen, 1);
   endtask

   task automatic wait_drain(input string name, input int limit);
      for (int c = 0; c < limit && exp_q.size() != 0; c++) @(negedge clk);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic begin_run(input bit poke_in_load);
      push_run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_trigger", busy, 1);
      if (poke_in_load) pulse_start();
      repeat (poke_in_load ? 3 : 4) @(posedge clk);
      #1 load_ready = 1'b1;
      @(posedge clk); #1 load_ready = 1'b0;
   endtask

   task automatic apply_reset(input string name);
      #3 rst_n = 1'b0;
      #1 check(name, all_outputs(), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Power-on reset
      #2 rst_n = 1'b0;
      #1 check("reset_outputs", all_outputs(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);

      // Full run with start pulses in LOAD, mid-L1, mid-L2 and in DONE
      begin_run(1'b1);
      repeat (3000) @(posedge clk);
      pulse_start();
      wait_write(1'b1, 3, "reach_l2_write3");
      pulse_start();
      wait_write(1'b1, 9, "reach_l2_write9");
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_drain("run_a_pending_events", 200);
      repeat (3) @(posedge clk); #1;
      check("idle_after_run_a", busy, 0);

      // Reset while layer 1 is on neuron 7, then a clean run
      begin_run(1'b0);
      wait_write(1'b0, 6, "reach_l1_write6");
      repeat (400) @(posedge clk);
      apply_reset("midrun_reset_outputs");
      @(posedge clk); #1;
      check("idle_after_midrun_reset", busy, 0);
      begin_run(1'b0);
      wait_drain("run_b_pending_events", 30000);

      // Loader never ready
      push(EV_LT, 0, 0, 0, -1);
`ifdef SNN_CTRL_WDOG_EN
      push(EV_ERR, 0, 0, 0, LOAD_TIMEOUT);
`endif
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (LOAD_TIMEOUT + 60) @(posedge clk);
      #1;
`ifdef SNN_CTRL_WDOG_EN
      check("busy_after_watchdog", busy, 0);
`else
      check("busy_while_stalled", busy, 1);
      check("err_while_stalled", err, 0);
      check("mac_en_while_stalled", mac_cnt, 0);
`endif
      wait_drain("stall_pending_events", 10);
      apply_reset("final_reset_outputs");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
